// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock,
// through a single registered borrow. Operands are captured on an accepted
// start. Results are presented with a one-cycle done pulse and then held
// until the next operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // One bit-step of the full subtractor, used on every RUN edge
    logic             d_bit_s;
    logic             br_next_s;
    logic [WIDTH-1:0] res_shift_s;

    // Next-state, bit-step datapath and result capture
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        res_d     = res_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        diff_d    = diff_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;

        d_bit_s     = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next_s   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        res_shift_s = {d_bit_s, res_q[WIDTH-1:1]};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                res_d = res_shift_s;
                br_d  = br_next_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last bit-step: publish the completed result this edge
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    diff_d  = res_shift_s;
                    bout_d  = br_next_s;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (res_shift_s[WIDTH-1] ^ a_msb_q);
                    zero_d  = ~|res_shift_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 2, 8 and 16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_drv;
    int          sel;
    logic [63:0] a_drv, b_drv;
    logic        bin_drv;

    always #5 clk = ~clk;

    logic st2, st8, st16;
    assign st2  = start_drv && (sel == 2);
    assign st8  = start_drv && (sel == 8);
    assign st16 = start_drv && (sel == 16);

    logic        busy2, done2, bout2, ovf2, zero2;
    logic [1:0]  diff2;
    logic        busy8, done8, bout8, ovf8, zero8;
    logic [7:0]  diff8;
    logic        busy16, done16, bout16, ovf16, zero16;
    logic [15:0] diff16;

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .a(a_drv[1:0]), .b(b_drv[1:0]), .bin(bin_drv),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2), .zero(zero2));
    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a_drv[7:0]), .b(b_drv[7:0]), .bin(bin_drv),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8));
    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a_drv[15:0]), .b(b_drv[15:0]), .bin(bin_drv),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16), .zero(zero16));

    // Outputs of the currently selected instance
    logic        busy_m, done_m, bout_m, ovf_m, zero_m;
    logic [63:0] diff_m;
    always_comb begin
        case (sel)
            2: begin
                busy_m = busy2; done_m = done2; bout_m = bout2; ovf_m = ovf2; zero_m = zero2;
                diff_m = {62'd0, diff2};
            end
            16: begin
                busy_m = busy16; done_m = done16; bout_m = bout16; ovf_m = ovf16; zero_m = zero16;
                diff_m = {48'd0, diff16};
            end
            default: begin
                busy_m = busy8; done_m = done8; bout_m = bout8; ovf_m = ovf8; zero_m = zero8;
                diff_m = {56'd0, diff8};
            end
        endcase
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        res_t        exp;
    } vec_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: unsigned and signed integer subtraction
    function automatic res_t ref_model(int w, logic [63:0] a, logic [63:0] b, logic bin);
        res_t        r;
        logic [63:0] mask;
        longint      ua, ub, half, full, sa, sb, s, bi;
        mask   = (64'd1 << w) - 64'd1;
        ua     = longint'(a & mask);
        ub     = longint'(b & mask);
        half   = longint'(64'd1 << (w - 1));
        bi     = bin ? 64'sd1 : 64'sd0;
        full   = ua - ub - bi;
        r.bout = (full < 0);
        r.diff = 64'(full) & mask;
        sa     = (ua >= half) ? ua - 2 * half : ua;
        sb     = (ub >= half) ? ub - 2 * half : ub;
        s      = sa - sb - bi;
        r.ovf  = (s < -half) || (s >= half);
        r.zero = (r.diff == 64'd0);
        return r;
    endfunction

    // One operation with exact busy/done timing checks; enter and leave at a negedge, DUT idle
    task automatic run_op(int w, logic [63:0] a, logic [63:0] b, logic bin, res_t e, string tag);
        sel       = w;
        a_drv     = a;
        b_drv     = b;
        bin_drv   = bin;
        start_drv = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= w; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_drv = 1'b0;
                a_drv     = {$urandom, $urandom};
                b_drv     = {$urandom, $urandom};
                bin_drv   = ~bin;
            end
            chk($sformatf("%s busy c%0d", tag, k), busy_m, 64'd1);
            chk($sformatf("%s done-early c%0d", tag, k), done_m, 64'd0);
        end
        @(negedge clk);
        chk($sformatf("%s done", tag), done_m, 64'd1);
        chk($sformatf("%s busy-at-done", tag), busy_m, 64'd0);
        chk($sformatf("%s diff", tag), diff_m, e.diff);
        chk($sformatf("%s bout", tag), bout_m, e.bout);
        chk($sformatf("%s ovf", tag), ovf_m, e.ovf);
        chk($sformatf("%s zero", tag), zero_m, e.zero);
        @(negedge clk);
        chk($sformatf("%s done-pulse-len", tag), done_m, 64'd0);
        chk($sformatf("%s busy-after", tag), busy_m, 64'd0);
        chk($sformatf("%s diff-held", tag), diff_m, e.diff);
    endtask

    vec_t        vecs[7];
    res_t        e;
    logic [63:0] ra, rb;
    logic        rbin;
    int          acc[$];
    int          ndone;
    logic        pb;
    logic [63:0] ha[30], hb[30];
    logic        hbin[30];

    initial begin
        vecs[0] = '{64'h50, 64'h30, 1'b0, '{64'h20, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{64'h30, 64'h50, 1'b0, '{64'hE0, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{64'h80, 64'h01, 1'b0, '{64'h7F, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{64'h00, 64'h00, 1'b1, '{64'hFF, 1'b1, 1'b0, 1'b0}};
        vecs[4] = '{64'h42, 64'h42, 1'b0, '{64'h00, 1'b0, 1'b0, 1'b1}};
        vecs[5] = '{64'h7F, 64'hFF, 1'b0, '{64'h80, 1'b1, 1'b1, 1'b0}};
        vecs[6] = '{64'hFF, 64'hFF, 1'b1, '{64'hFF, 1'b1, 1'b0, 1'b0}};

        rst_n = 1'b0; start_drv = 1'b0; sel = 8;
        a_drv = 64'd0; b_drv = 64'd0; bin_drv = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset busy", busy_m, 64'd0);
        chk("reset done", done_m, 64'd0);
        chk("reset diff", diff_m, 64'd0);
        chk("reset bout", bout_m, 64'd0);
        chk("reset ovf", ovf_m, 64'd0);
        chk("reset zero", zero_m, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors at WIDTH 8
        for (int i = 0; i < 7; i++)
            run_op(8, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));

        // start held high: accepts every WIDTH+2 cycles, operands churn every cycle
        sel = 8; ndone = 0; pb = 1'b0;
        for (int n = 0; n < 30; n++) begin
            ha[n] = {$urandom, $urandom};
            hb[n] = {$urandom, $urandom};
            hbin[n] = 1'($urandom_range(0, 1));
            a_drv = ha[n]; b_drv = hb[n]; bin_drv = hbin[n]; start_drv = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("held overlap n%0d", n), {63'd0, busy_m & done_m}, 64'd0);
            if (busy_m && !pb) acc.push_back(n);
            if (done_m) begin
                ndone++;
                if (acc.size() > 0) begin
                    e = ref_model(8, ha[acc[$]], hb[acc[$]], hbin[acc[$]]);
                    chk($sformatf("held diff n%0d", n), diff_m, e.diff);
                    chk($sformatf("held bout n%0d", n), bout_m, e.bout);
                    chk($sformatf("held ovf n%0d", n), ovf_m, e.ovf);
                end
            end
            pb = busy_m;
        end
        start_drv = 1'b0;
        chk("held accept count", 64'(acc.size()), 64'd3);
        chk("held done count", 64'(ndone), 64'd3);
        for (int k = 0; k < acc.size() && k < 3; k++)
            chk($sformatf("held accept edge %0d", k), 64'(acc[k]), 64'(k * 10));
        repeat (12) @(negedge clk);

        // Asynchronous reset in the fourth RUN cycle aborts and clears results
        run_op(8, 64'h50, 64'h30, 1'b0, vecs[0].exp, "pre-reset");
        a_drv = 64'h11; b_drv = 64'h22; bin_drv = 1'b0; start_drv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_drv = 1'b0;
        chk("abort running", busy_m, 64'd1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy_m, 64'd0);
        chk("abort done", done_m, 64'd0);
        chk("abort diff", diff_m, 64'd0);
        chk("abort bout", bout_m, 64'd0);
        chk("abort ovf", ovf_m, 64'd0);
        chk("abort zero", zero_m, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("abort no-done c%0d", k), done_m, 64'd0);
            chk($sformatf("abort idle c%0d", k), busy_m, 64'd0);
        end
        e = ref_model(8, 64'h05, 64'h03, 1'b0);
        chk("post-reset model", e.diff, 64'h02);
        run_op(8, 64'h05, 64'h03, 1'b0, e, "post-reset");

        // Randomised sweeps against the arithmetic model
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rbin = 1'($urandom_range(0, 1));
            run_op(2, ra, rb, rbin, ref_model(2, ra, rb, rbin), $sformatf("w2 #%0d", i));
        end
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rbin = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ra;
            run_op(16, ra, rb, rbin, ref_model(16, ra, rb, rbin), $sformatf("w16 #%0d", i));
        end
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rbin = 1'($urandom_range(0, 1));
            run_op(8, ra, rb, rbin, ref_model(8, ra, rb, rbin), $sformatf("w8 #%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
